mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words (power of 2).
REQ-002 SHALL have parameter LATENCY, default 2, extra wait cycles before an instruction-port response (0..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-004 SHALL have parameter INIT_FILE, default "", hex image loaded at elaboration if non-empty.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, ports as below.
REQ-006 i_clk  input  1  clock, all state updates on rising edge.
REQ-007 i_rst  input  1  asynchronous active-low reset.
REQ-008 i_IM_DataReq  input  1  instruction refill request, held high until served.
REQ-009 i_IM_Addr  input  XLEN  instruction refill byte address.
REQ-010 o_IM_MemReady  output  1  one-cycle response-valid pulse.
REQ-011 o_IM_DataBlock  output  XLEN  refill word, valid while o_IM_MemReady=1.
REQ-012 o_IM_Err  output  1  out-of-range flag, valid while o_IM_MemReady=1.
REQ-013 i_DM_Addr  input  XLEN  data byte address.
REQ-014 i_DM_Wd  input  XLEN  store data, right-aligned.
REQ-015 i_DM_f3  input  3  access size: f3[1:0] 00 byte, 01 half, 10 word.
REQ-016 i_DM_Wen  input  1  store enable.
REQ-017 i_DM_MemRead  input  1  load enable.
REQ-018 o_DM_ReadData  output  XLEN  load data, right-aligned, no extension.

Function
REQ-019 Instruction port FSM SHALL have states IDLE, WAIT, RESP.
REQ-020 IDLE: i_IM_DataReq=1 at an edge -> word index (i_IM_Addr-BASE_ADDR)>>2 captured; next state WAIT with counter=LATENCY-1, or RESP if LATENCY=0.
REQ-021 WAIT: counter decrements each edge; at counter=0 next state RESP.
REQ-022 o_IM_MemReady SHALL be 1 only in RESP, exactly in the cycle after edge k+LATENCY, where k is the capture edge.
REQ-023 RESP SHALL return to IDLE unconditionally; a request still high in the following IDLE cycle starts a new transaction.
REQ-024 i_IM_DataReq dropping in WAIT SHALL abort to IDLE with no MemReady pulse.
REQ-025 i_IM_Addr changes after capture SHALL be ignored; address bits [1:0] ignored.
REQ-026 o_IM_DataBlock in RESP SHALL be array content at the captured index during that cycle, so a store committed at an earlier edge is visible.
REQ-027 Captured index >= DEPTH or address < BASE_ADDR -> o_IM_DataBlock=0 and o_IM_Err=1 in RESP.
REQ-028 o_IM_DataBlock and o_IM_Err SHALL be 0 outside RESP.
REQ-029 Load SHALL be combinational: o_DM_ReadData = word at index >> (8*i_DM_Addr[1:0]) when i_DM_MemRead=1, else 0; out-of-range -> 0.
REQ-030 Store SHALL commit at the rising edge with i_DM_Wen=1: byte -> lane addr[1:0]; half -> lanes {addr[1],0},{addr[1],1}; word -> all lanes; f3[1:0]=11 or out-of-range -> no write.
REQ-031 Unselected byte lanes SHALL be unchanged by a store.
REQ-032 i_DM_Wen and i_DM_MemRead both high -> load returns pre-write content, write commits at the edge.

Reset
REQ-033 i_rst=0 SHALL immediately force IDLE, counter=0, o_IM_MemReady=0, o_IM_DataBlock=0, o_IM_Err=0, regardless of clock.
REQ-034 Reset mid-WAIT or mid-RESP SHALL abort the transaction; no MemReady after release until a new request.
REQ-035 Reset SHALL NOT clear memory array contents; stores are blocked while i_rst=0.

Verification
REQ-036 LATENCY=2, mem[4]=32'hDEADBEEF, i_IM_DataReq=1 with i_IM_Addr=32'h10 at edge k -> o_IM_MemReady=1 and o_IM_DataBlock=32'hDEADBEEF only in cycle after edge k+2.
REQ-037 LATENCY=0, back-to-back requests 32'h0 then 32'h4 -> MemReady pulses separated by exactly one IDLE cycle with correct words.
REQ-038 Word 32'h11223344 at 32'h8; sb 8'hAA to 32'h9, then lhu-style read of 32'hA -> o_DM_ReadData=32'h00001122; word read -> 32'h1122AA44.
REQ-039 Request in WAIT, i_IM_DataReq dropped one cycle -> no MemReady; request to DEPTH*4 -> MemReady with DataBlock=0, Err=1.
REQ-040 Reset asserted mid-WAIT, released 2 cycles later -> outputs 0 asynchronously, no response, memory preserved on subsequent read.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Word-organised memory with a latency-controlled instruction
//               refill port (IDLE/WAIT/RESP handshake) and a combinational
//               load / edge-committed store data port with byte lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int               XLEN      = 32,
    parameter int               DEPTH     = 1024,
    parameter int               LATENCY   = 2,
    parameter logic [XLEN-1:0]  BASE_ADDR = 32'h0,
    parameter                   INIT_FILE = ""
) (
    input  logic            i_clk,
    input  logic            i_rst,
    // instruction refill port
    input  logic            i_IM_DataReq,
    input  logic [XLEN-1:0] i_IM_Addr,
    output logic            o_IM_MemReady,
    output logic [XLEN-1:0] o_IM_DataBlock,
    output logic            o_IM_Err,
    // data port
    input  logic [XLEN-1:0] i_DM_Addr,
    input  logic [XLEN-1:0] i_DM_Wd,
    input  logic [2:0]      i_DM_f3,
    input  logic            i_DM_Wen,
    input  logic            i_DM_MemRead,
    output logic [XLEN-1:0] o_DM_ReadData
);

    localparam int AW = $clog2(DEPTH);

    // Counter preload for WAIT; unused when LATENCY is zero.
    localparam logic [3:0] c_lat_init = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [XLEN-1:0] mem_q [DEPTH];

    state_t          state_q, state_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic [AW-1:0]   idx_q,   idx_d;
    logic            err_q,   err_d;

    // Address decode: byte offset from BASE_ADDR, word index and range test.
    logic [XLEN-1:0] w_im_off;
    logic [AW-1:0]   w_im_idx;
    logic            w_im_oor;
    logic [XLEN-1:0] w_dm_off;
    logic [AW-1:0]   w_dm_idx;
    logic            w_dm_oor;
    logic [XLEN-1:0] w_dm_word;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic            w_resp;

    assign w_im_off = i_IM_Addr - BASE_ADDR;
    assign w_im_idx = w_im_off[AW+1:2];
    assign w_im_oor = (i_IM_Addr < BASE_ADDR) || (w_im_off[XLEN-1:AW+2] != '0);

    assign w_dm_off = i_DM_Addr - BASE_ADDR;
    assign w_dm_idx = w_dm_off[AW+1:2];
    assign w_dm_oor = (i_DM_Addr < BASE_ADDR) || (w_dm_off[XLEN-1:AW+2] != '0);

    // Sub-word offset bits and f3[2] carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, i_DM_f3[2], w_im_off[1:0], w_dm_off[1:0]};

    // Instruction FSM state register; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Next-state: capture in IDLE, count down in WAIT, single-cycle RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_IM_DataReq) begin
                    idx_d = w_im_idx;
                    err_d = w_im_oor;
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = c_lat_init;
                    end
                end
            end
            S_WAIT: begin
                if (!i_IM_DataReq) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response reads the array live, so earlier-committed stores are seen.
    assign w_resp         = (state_q == S_RESP);
    assign o_IM_MemReady  = w_resp;
    assign o_IM_Err       = w_resp && err_q;
    assign o_IM_DataBlock = (w_resp && !err_q) ? mem_q[idx_q] : '0;

    // Loads are combinational and return pre-write content on a same-cycle store.
    assign w_dm_word     = mem_q[w_dm_idx];
    assign o_DM_ReadData = (i_DM_MemRead && !w_dm_oor)
                         ? (w_dm_word >> {i_DM_Addr[1:0], 3'b000}) : '0;

    // Store lane selection and data replication across the selected lanes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = '0;
        unique case (i_DM_f3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_DM_Addr[1:0];
                w_wdata = {4{i_DM_Wd[7:0]}};
            end
            2'b01: begin
                w_be    = i_DM_Addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_DM_Wd[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = i_DM_Wd;
            end
            default: w_be = 4'b0000;
        endcase
        if (!i_DM_Wen || w_dm_oor) begin
            w_be = 4'b0000;
        end
    end

    // Array write; contents survive reset but stores are blocked while in reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_rst && w_be[b]) begin
                mem_q[w_dm_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Scoreboard bench for mem_responder. Two instances (LATENCY=2
//               and LATENCY=0) share reset and the data port so their arrays
//               stay identical; a reference array models the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        im_req2, im_req0;
    logic [31:0] im_addr2, im_addr0;
    logic [31:0] dm_addr, dm_wd;
    logic [2:0]  dm_f3;
    logic        dm_wen, dm_rd;

    logic        rdy2, err2, rdy0, err0;
    logic [31:0] data2, data0, rdata2, rdata0;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst_n),
        .i_IM_DataReq(im_req2), .i_IM_Addr(im_addr2),
        .o_IM_MemReady(rdy2), .o_IM_DataBlock(data2), .o_IM_Err(err2),
        .i_DM_Addr(dm_addr), .i_DM_Wd(dm_wd), .i_DM_f3(dm_f3),
        .i_DM_Wen(dm_wen), .i_DM_MemRead(dm_rd), .o_DM_ReadData(rdata2)
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst_n),
        .i_IM_DataReq(im_req0), .i_IM_Addr(im_addr0),
        .o_IM_MemReady(rdy0), .o_IM_DataBlock(data0), .o_IM_Err(err0),
        .i_DM_Addr(dm_addr), .i_DM_Wd(dm_wd), .i_DM_f3(dm_f3),
        .i_DM_Wen(dm_wen), .i_DM_MemRead(dm_rd), .o_DM_ReadData(rdata0)
    );

    typedef struct {
        int cyc;
        int idx;
        bit err;
    } exp_t;

    exp_t        q2[$];
    exp_t        q0[$];
    logic [31:0] model_mem [DEPTH];
    int          edge_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic [31:0] a);
        return a >= 32'(DEPTH * 4);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a);
        if (model_err(a)) return 32'h0;
        return model_mem[int'(a >> 2)] >> (8 * a[1:0]);
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                        input logic [2:0] f3);
        logic [31:0] w;
        if (model_err(a)) return;
        w = model_mem[int'(a >> 2)];
        case (f3[1:0])
            2'b00: w[8*a[1:0] +: 8] = d[7:0];
            2'b01: if (a[1]) w[31:16] = d[15:0]; else w[15:0] = d[15:0];
            2'b10: w = d;
            default: return;
        endcase
        model_mem[int'(a >> 2)] = w;
    endfunction

    // ---------------- monitor ----------------
    task automatic check_resp(input string name, input exp_t e,
                              input logic [31:0] data, input logic err);
        logic [31:0] exp_data;
        exp_data = e.err ? 32'h0 : model_mem[e.idx];
        chk({name, "_cycle"}, 32'(edge_cnt), 32'(e.cyc));
        chk({name, "_data"}, data, exp_data);
        chk({name, "_err"}, {31'h0, err}, {31'h0, e.err});
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected: MemReady=1 with no pending request (t=%0t)", name, $time);
    endtask

    exp_t e2, e0;
    always @(negedge clk) begin
        if (rdy2) begin
            if (q2.size() == 0) unexpected("im2");
            else begin
                e2 = q2.pop_front();
                check_resp("im2", e2, data2, err2);
            end
        end else begin
            chk("im2_idle_out", {data2[31:1], data2[0] | err2}, 32'h0);
        end
        if (rdy0) begin
            if (q0.size() == 0) unexpected("im0");
            else begin
                e0 = q0.pop_front();
                check_resp("im0", e0, data0, err0);
            end
        end else begin
            chk("im0_idle_out", {data0[31:1], data0[0] | err0}, 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        dm_addr = a; dm_wd = d; dm_f3 = f3; dm_wen = 1'b1; dm_rd = 1'b0;
        @(posedge clk);
        if (rst_n) model_store(a, d, f3);
        #1;
        dm_wen = 1'b0;
    endtask

    task automatic load_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        dm_addr = a; dm_rd = 1'b1; dm_wen = 1'b0;
        #1;
        chk(name, rdata2, exp);
        dm_rd = 1'b0;
        tick();
    endtask

    // LATENCY=2 request held through the response cycle, address scrambled
    // after capture, optional store to the captured word while waiting.
    task automatic im_req_l2(input logic [31:0] a, input bit do_store);
        exp_t e;
        e.cyc = edge_cnt + 3;
        e.err = model_err(a);
        e.idx = e.err ? 0 : int'(a >> 2);
        q2.push_back(e);
        im_req2 = 1'b1; im_addr2 = a;
        tick();
        im_addr2 = $urandom;
        if (do_store && !e.err) store(32'(e.idx * 4), $urandom, 3'b010);
        else tick();
        tick();
        im_req2 = 1'b0;
        tick();
    endtask

    task automatic im_req_l0(input logic [31:0] a);
        exp_t e;
        e.cyc = edge_cnt + 1;
        e.err = model_err(a);
        e.idx = e.err ? 0 : int'(a >> 2);
        q0.push_back(e);
        im_req0 = 1'b1; im_addr0 = a;
        tick();
        im_req0 = 1'b0;
        tick();
    endtask

    task automatic rst_zero_chk(input string name);
        chk({name, "_rdy"}, {31'h0, rdy2}, 32'h0);
        chk({name, "_data"}, data2, 32'h0);
        chk({name, "_err"}, {31'h0, err2}, 32'h0);
    endtask

    initial begin
        im_req2 = 1'b0; im_req0 = 1'b0; im_addr2 = '0; im_addr0 = '0;
        dm_addr = '0; dm_wd = '0; dm_f3 = 3'b010; dm_wen = 1'b0; dm_rd = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_zero_chk("reset_state");
        chk("reset_state_rdy0", {31'h0, rdy0}, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Fill the whole array so every word has a known value.
        for (int i = 0; i < DEPTH; i++) store(32'(i * 4), $urandom, 3'b010);

        // Basic LATENCY=2 refill.
        store(32'h10, 32'hDEADBEEF, 3'b010);
        im_req_l2(32'h10, 1'b0);

        // Byte store then half/word loads.
        store(32'h8, 32'h11223344, 3'b010);
        store(32'h9, 32'h000000AA, 3'b000);
        load_chk("lhu_A", 32'hA, 32'h00001122);
        load_chk("lw_8", 32'h8, 32'h1122AA44);

        // Same-cycle load and store: load sees old data.
        dm_addr = 32'h8; dm_wd = 32'h55667788; dm_f3 = 3'b010; dm_wen = 1'b1; dm_rd = 1'b1;
        #1;
        chk("rd_during_wr", rdata2, 32'h1122AA44);
        @(posedge clk);
        model_store(32'h8, 32'h55667788, 3'b010);
        #1;
        dm_wen = 1'b0; dm_rd = 1'b0;
        load_chk("after_wr", 32'h8, 32'h55667788);

        // Stores that must not write.
        store(32'h8, 32'hFFFFFFFF, 3'b011);
        load_chk("f3_11_nowr", 32'h8, 32'h55667788);
        store(32'(DEPTH * 4), 32'hFFFFFFFF, 3'b010);
        load_chk("ld_oor", 32'(DEPTH * 4), 32'h0);
        store(32'hE, 32'h0000BEEF, 3'b001);
        load_chk("sh_upper", 32'hC, model_load(32'hC));

        // LATENCY=0 back-to-back: pulses one IDLE cycle apart.
        begin
            exp_t a0, a1;
            a0.cyc = edge_cnt + 1; a0.idx = 0; a0.err = 1'b0;
            a1.cyc = edge_cnt + 3; a1.idx = 1; a1.err = 1'b0;
            q0.push_back(a0);
            q0.push_back(a1);
            im_req0 = 1'b1; im_addr0 = 32'h0;
            tick();
            im_addr0 = 32'h4;
            tick();
            tick();
            im_req0 = 1'b0;
            tick();
        end

        // Abort in WAIT: no response.
        im_req2 = 1'b1; im_addr2 = 32'h10;
        tick();
        im_req2 = 1'b0;
        repeat (5) tick();

        // Out-of-range refill.
        im_req_l2(32'(DEPTH * 4), 1'b0);

        // Reset in RESP drops the pulse immediately.
        im_req2 = 1'b1; im_addr2 = 32'h8;
        repeat (3) tick();
        chk("resp_before_rst", {31'h0, rdy2}, 32'h1);
        chk("resp_data_before_rst", data2, model_mem[2]);
        #1;
        rst_n = 1'b0; im_req2 = 1'b0;
        #1;
        rst_zero_chk("rst_in_resp");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Reset in WAIT, store attempted during reset, memory preserved.
        im_req2 = 1'b1; im_addr2 = 32'h10;
        tick();
        tick();
        #1;
        rst_n = 1'b0; im_req2 = 1'b0;
        #1;
        rst_zero_chk("rst_in_wait");
        store(32'h10, 32'h0, 3'b010);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        load_chk("mem_kept", 32'h10, 32'hDEADBEEF);
        im_req_l2(32'h10, 1'b0);

        // Store during WAIT is visible in the response.
        im_req_l2(32'h20, 1'b1);

        // Randomised mix.
        for (int it = 0; it < 80; it++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            a  = 32'($urandom_range(0, DEPTH * 4 + 15));
            case (op)
                0: store(a, $urandom, 3'($urandom_range(0, 3)));
                1: load_chk("ld_rand", a, model_load(a));
                2: im_req_l2(a, 1'($urandom_range(0, 1)));
                default: im_req_l0(a);
            endcase
        end

        repeat (4) tick();
        chk("q2_drained", 32'(q2.size()), 32'h0);
        chk("q0_drained", 32'(q0.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
